// File: rtl/fpu_i2c_sequencer_if.sv
// Bundle of command, FPU and I2C-master signals seen by the result sequencer.
// The master side is the sequencer; the slave side is its environment.
interface fpu_i2c_sequencer_if;
  logic        cmd_valid;
  logic [65:0] cmd_data;
  logic        cmd_ready;
  logic        fpu_start;
  logic [1:0]  fpu_op;
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic        fpu_done;
  logic [31:0] fpu_result;
  logic        i2c_req;
  logic [6:0]  i2c_addr;
  logic [7:0]  i2c_data;
  logic        i2c_busy;
  logic        i2c_nack;
  logic        done;
  logic        complete;
  logic        err;
  logic [31:0] result;

  modport master (
    input  cmd_valid, cmd_data, fpu_done, fpu_result, i2c_busy, i2c_nack,
    output cmd_ready, fpu_start, fpu_op, fpu_a, fpu_b, i2c_req, i2c_addr,
           i2c_data, done, complete, err, result
  );

  modport slave (
    output cmd_valid, cmd_data, fpu_done, fpu_result, i2c_busy, i2c_nack,
    input  cmd_ready, fpu_start, fpu_op, fpu_a, fpu_b, i2c_req, i2c_addr,
           i2c_data, done, complete, err, result
  );
endinterface

// File: rtl/fpu_i2c_sequencer.sv
// Runs one FPU operation per command, then ships the 32-bit result MSB-first
// as byte writes to a fixed I2C slave, with NACK retry and FPU timeout.
module fpu_i2c_sequencer #(
  parameter logic [6:0]  SLAVE_ADDR  = 7'b0001101,
  parameter int          NUM_BYTES   = 4,
  parameter int          FPU_TIMEOUT = 64,
  parameter int          RETRY_MAX   = 2,
  parameter logic [31:0] NAN_VALUE   = 32'h7FC00000
) (
  input logic                 clk,
  input logic                 reset,
  fpu_i2c_sequencer_if.master bus
);
  localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int CNT_W = (FPU_TIMEOUT > 1) ? $clog2(FPU_TIMEOUT) : 1;
  localparam int RTY_W = $clog2(RETRY_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_FPU, S_CAPT, S_SEND, S_WAIT_HI, S_WAIT_LO, S_FIN
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] tmo_cnt;
  logic [IDX_W-1:0] byte_idx;
  logic [RTY_W-1:0] retry;
  logic             err_pending;

  // Byte idx of the word, counting from the most significant end.
  function automatic logic [7:0] sel_byte(input logic [31:0] word,
                                          input logic [IDX_W-1:0] idx);
    logic [31:0] shifted;
    shifted = word << {idx, 3'b000};
    return shifted[31:24];
  endfunction

  assign bus.i2c_addr = SLAVE_ADDR;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      bus.cmd_ready <= 1'b1;
      bus.fpu_start <= 1'b0;
      bus.fpu_op    <= '0;
      bus.fpu_a     <= '0;
      bus.fpu_b     <= '0;
      bus.i2c_req   <= 1'b0;
      bus.i2c_data  <= '0;
      bus.done      <= 1'b0;
      bus.complete  <= 1'b0;
      bus.err       <= 1'b0;
      bus.result    <= '0;
      tmo_cnt       <= '0;
      byte_idx      <= '0;
      retry         <= '0;
      err_pending   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid && bus.cmd_ready) begin
            bus.fpu_op    <= bus.cmd_data[65:64];
            bus.fpu_a     <= bus.cmd_data[63:32];
            bus.fpu_b     <= bus.cmd_data[31:0];
            bus.err       <= 1'b0;
            bus.cmd_ready <= 1'b0;
            // Op 11 has no FPU meaning: skip the FPU and report a quiet NaN.
            if (bus.cmd_data[65:64] == 2'b11) begin
              bus.result  <= NAN_VALUE;
              err_pending <= 1'b1;
              bus.done    <= 1'b1;
              state       <= S_CAPT;
            end else begin
              err_pending   <= 1'b0;
              bus.fpu_start <= 1'b1;
              state         <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          bus.fpu_start <= 1'b0;
          tmo_cnt       <= '0;
          state         <= S_WAIT_FPU;
        end
        S_WAIT_FPU: begin
          if (bus.fpu_done) begin
            bus.result <= bus.fpu_result;
            bus.done   <= 1'b1;
            state      <= S_CAPT;
          end else if (tmo_cnt == CNT_W'(FPU_TIMEOUT - 1)) begin
            bus.result  <= NAN_VALUE;
            err_pending <= 1'b1;
            bus.done    <= 1'b1;
            state       <= S_CAPT;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_CAPT: begin
          bus.done     <= 1'b0;
          byte_idx     <= '0;
          retry        <= '0;
          bus.i2c_req  <= 1'b1;
          bus.i2c_data <= sel_byte(bus.result, '0);
          state        <= S_SEND;
        end
        S_SEND: begin
          bus.i2c_req <= 1'b0;
          state       <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          if (bus.i2c_busy) state <= S_WAIT_LO;
        end
        S_WAIT_LO: begin
          // i2c_nack is only meaningful in the cycle busy is seen low.
          if (!bus.i2c_busy) begin
            if (!bus.i2c_nack) begin
              if (byte_idx == IDX_W'(NUM_BYTES - 1)) begin
                bus.complete <= 1'b1;
                bus.err      <= err_pending;
                state        <= S_FIN;
              end else begin
                byte_idx     <= byte_idx + 1'b1;
                retry        <= '0;
                bus.i2c_req  <= 1'b1;
                bus.i2c_data <= sel_byte(bus.result, byte_idx + 1'b1);
                state        <= S_SEND;
              end
            end else if (retry < RTY_W'(RETRY_MAX)) begin
              retry        <= retry + 1'b1;
              bus.i2c_req  <= 1'b1;
              bus.i2c_data <= sel_byte(bus.result, byte_idx);
              state        <= S_SEND;
            end else begin
              err_pending  <= 1'b1;
              bus.complete <= 1'b1;
              bus.err      <= 1'b1;
              state        <= S_FIN;
            end
          end
        end
        S_FIN: begin
          bus.complete  <= 1'b0;
          bus.cmd_ready <= 1'b1;
          state         <= S_IDLE;
        end
        default: begin
          bus.cmd_ready <= 1'b1;
          state         <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_i2c_sequencer.sv
// Scoreboard bench: stimulus queues expected events, a monitor pops and checks
// them; behavioural FPU and I2C-master models answer the sequencer.
module tb_fpu_i2c_sequencer;
  localparam logic [6:0]  ADDR = 7'b0001101;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [65:0] CMD_ADD = {2'b00, 32'h40A00000, 32'h40400000};
  localparam logic [65:0] CMD_SUB = {2'b01, 32'h40A00000, 32'h40400000};
  localparam logic [65:0] CMD_BAD = {2'b11, 32'h40A00000, 32'h40400000};
  localparam logic [65:0] CMD_MUL = {2'b10, 32'h40000000, 32'h40400000};

  typedef struct { int kind; logic [65:0] d; } ev_t;
  typedef struct { int dly; logic [31:0] val; } fpu_rsp_t;

  logic clk;
  logic reset;
  fpu_i2c_sequencer_if bus();

  fpu_i2c_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;
  int n_start  = 0;
  int n_req    = 0;
  int n_cmp    = 0;
  int cyc      = 0;
  int t_acc    = 0;
  int t_start  = 0;
  int t_fall   = 0;
  int t_cmp    = 0;
  ev_t      sb[$];
  fpu_rsp_t fpu_q[$];
  bit       nack_q[$];
  int       start_lat_q[$];
  int       done_lat_q[$];
  int       cmp_lat_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, need %0h", name, act, exp);
  endtask

  function automatic string kname(input int k);
    case (k)
      0: return "fpu_start";
      1: return "done";
      2: return "i2c_req";
      default: return "complete";
    endcase
  endfunction

  task automatic push_ev(input int kind, input logic [65:0] d);
    ev_t e;
    e.kind = kind;
    e.d    = d;
    sb.push_back(e);
  endtask

  task automatic expect_head(input logic [65:0] cmd, input logic [31:0] res);
    if (cmd[65:64] != 2'b11) push_ev(0, cmd);
    push_ev(1, {34'd0, res});
  endtask

  task automatic push_req(input logic [7:0] b);
    push_ev(2, {58'd0, b});
  endtask

  task automatic push_cmp(input logic e);
    push_ev(3, {65'd0, e});
  endtask

  task automatic got(input int kind, input logic [65:0] d);
    ev_t e;
    if (sb.size() == 0) begin
      n_checks++;
      $display("FAIL unexpected_%s: got %0h, need no event", kname(kind), d);
      return;
    end
    e = sb.pop_front();
    chk({"ev_kind_", kname(e.kind)}, 66'(kind), 66'(e.kind));
    chk({"ev_data_", kname(e.kind)}, d, e.d);
  endtask

  // Monitor: every DUT pulse is matched against the scoreboard in order.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.fpu_start) begin
          n_start++;
          start_lat_q.push_back(cyc - t_acc);
          t_start = cyc;
          got(0, {bus.fpu_op, bus.fpu_a, bus.fpu_b});
        end
        if (bus.done) begin
          done_lat_q.push_back(cyc - t_start);
          got(1, {34'd0, bus.result});
        end
        if (bus.i2c_req) begin
          n_req++;
          chk("i2c_addr", {59'd0, bus.i2c_addr}, {59'd0, ADDR});
          got(2, {58'd0, bus.i2c_data});
        end
        if (bus.complete) begin
          n_cmp++;
          cmp_lat_q.push_back(cyc - t_fall);
          t_cmp = cyc;
          got(3, {65'd0, bus.err});
        end
      end
    end
  end

  // FPU model: answers each start after the queued delay (negative = never).
  initial begin
    fpu_rsp_t f;
    bus.fpu_done   = 1'b0;
    bus.fpu_result = '0;
    forever begin
      @(negedge clk);
      if (bus.fpu_start && !reset) begin
        if (fpu_q.size() > 0) f = fpu_q.pop_front();
        else f = '{-1, 32'h0};
        if (f.dly >= 0) begin
          repeat (f.dly) @(negedge clk);
          bus.fpu_done   = 1'b1;
          bus.fpu_result = f.val;
          @(negedge clk);
          bus.fpu_done = 1'b0;
        end
      end
    end
  end

  // I2C master model: busy for 5 cycles per byte, NACK taken from nack_q.
  initial begin
    bus.i2c_busy = 1'b0;
    bus.i2c_nack = 1'b0;
    forever begin
      @(negedge clk);
      bus.i2c_nack = 1'b0;
      if (bus.i2c_req && !reset) begin
        bus.i2c_busy = 1'b1;
        repeat (5) @(negedge clk);
        bus.i2c_busy = 1'b0;
        bus.i2c_nack = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
        t_fall = cyc;
      end
    end
  end

  task automatic issue(input logic [65:0] cmd, input int dly, input logic [31:0] val);
    int n;
    if (cmd[65:64] != 2'b11) fpu_q.push_back('{dly, val});
    bus.cmd_data  = cmd;
    bus.cmd_valid = 1'b1;
    n = 0;
    while (!bus.cmd_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) begin
      n_checks++;
      $display("FAIL accept_timeout: cmd_ready=0 after %0d cycles, need 1", n);
    end
    t_acc = cyc;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_cmp(input int target);
    int n;
    n = 0;
    while (n_cmp < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("complete_count", 66'(n_cmp), 66'(target));
    @(negedge clk);
  endtask

  task automatic clear_lat();
    start_lat_q.delete();
    done_lat_q.delete();
    cmp_lat_q.delete();
  endtask

  initial begin
    int base;
    int rq;
    int cp;
    int n;
    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    repeat (3) @(negedge clk);

    chk("rst_cmd_ready", {65'd0, bus.cmd_ready}, 66'd1);
    chk("rst_i2c_addr",  {59'd0, bus.i2c_addr}, {59'd0, ADDR});
    chk("rst_pulses",    {62'd0, bus.fpu_start, bus.done, bus.i2c_req, bus.complete}, 66'd0);
    chk("rst_err",       {65'd0, bus.err}, 66'd0);
    chk("rst_result",    {34'd0, bus.result}, 66'd0);
    chk("rst_fpu_regs",  {bus.fpu_op, bus.fpu_a, bus.fpu_b}, 66'd0);
    reset = 1'b0;

    // Add 5+3, then a sub held on cmd_valid across the add's complete.
    expect_head(CMD_ADD, 32'h41000000);
    push_req(8'h41); push_req(8'h00); push_req(8'h00); push_req(8'h00);
    push_cmp(1'b0);
    expect_head(CMD_SUB, 32'h40000000);
    push_req(8'h40); push_req(8'h00); push_req(8'h00); push_req(8'h00);
    push_cmp(1'b0);
    issue(CMD_ADD, 5, 32'h41000000);
    issue(CMD_SUB, 5, 32'h40000000);
    chk("b2b_accept_after_fin", 66'(t_acc - t_cmp), 66'd1);
    wait_cmp(2);
    chk("add_sub_err", {65'd0, bus.err}, 66'd0);
    chk("start_lat_count", 66'(start_lat_q.size()), 66'd2);
    foreach (start_lat_q[i]) chk("accept_to_start", 66'(start_lat_q[i]), 66'd1);
    foreach (done_lat_q[i])  chk("start_to_done", 66'(done_lat_q[i]), 66'd6);
    foreach (cmp_lat_q[i])   chk("fall_to_complete", 66'(cmp_lat_q[i]), 66'd1);
    clear_lat();

    // Unknown op: no FPU activity, NaN sent, err raised.
    base = n_start;
    expect_head(CMD_BAD, QNAN);
    push_req(8'h7F); push_req(8'hC0); push_req(8'h00); push_req(8'h00);
    push_cmp(1'b1);
    issue(CMD_BAD, 0, 32'h0);
    wait_cmp(3);
    chk("bad_op_err", {65'd0, bus.err}, 66'd1);
    chk("bad_op_no_start", 66'(n_start), 66'(base));
    clear_lat();

    // Byte 1 NACKed twice, then ACKed.
    nack_q = {1'b0, 1'b1, 1'b1};
    expect_head(CMD_MUL, 32'h40C00000);
    push_req(8'h40); push_req(8'hC0); push_req(8'hC0); push_req(8'hC0);
    push_req(8'h00); push_req(8'h00);
    push_cmp(1'b0);
    issue(CMD_MUL, 3, 32'h40C00000);
    chk("err_cleared_on_accept", {65'd0, bus.err}, 66'd0);
    wait_cmp(4);
    chk("retry_ok_err", {65'd0, bus.err}, 66'd0);

    // Byte 1 NACKed three times: abort, bytes 2 and 3 never requested.
    nack_q = {1'b0, 1'b1, 1'b1, 1'b1};
    base = n_req;
    expect_head(CMD_MUL, 32'h40C00000);
    push_req(8'h40); push_req(8'hC0); push_req(8'hC0); push_req(8'hC0);
    push_cmp(1'b1);
    issue(CMD_MUL, 3, 32'h40C00000);
    wait_cmp(5);
    repeat (10) @(negedge clk);
    chk("abort_req_count", 66'(n_req - base), 66'd4);
    chk("abort_err", {65'd0, bus.err}, 66'd1);
    clear_lat();

    // FPU never answers: timeout substitutes NaN.
    expect_head(CMD_ADD, QNAN);
    push_req(8'h7F); push_req(8'hC0); push_req(8'h00); push_req(8'h00);
    push_cmp(1'b1);
    issue(CMD_ADD, -1, 32'h0);
    wait_cmp(6);
    chk("timeout_done_seen", 66'(done_lat_q.size()), 66'd1);
    if (done_lat_q.size() > 0) chk("timeout_start_to_done", 66'(done_lat_q[0]), 66'd65);
    chk("timeout_err", {65'd0, bus.err}, 66'd1);
    clear_lat();

    // Reset while waiting for busy to fall on byte 2.
    base = n_req;
    expect_head(CMD_MUL, 32'h40C00000);
    push_req(8'h40); push_req(8'hC0); push_req(8'h00);
    issue(CMD_MUL, 3, 32'h40C00000);
    n = 0;
    while (n_req < base + 3 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("pre_reset_reqs", 66'(n_req - base), 66'd3);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_cmd_ready", {65'd0, bus.cmd_ready}, 66'd1);
    chk("mid_rst_pulses", {62'd0, bus.fpu_start, bus.done, bus.i2c_req, bus.complete}, 66'd0);
    chk("mid_rst_err", {65'd0, bus.err}, 66'd0);
    rq = n_req;
    cp = n_cmp;
    repeat (20) @(negedge clk);
    chk("post_rst_no_req", 66'(n_req), 66'(rq));
    chk("post_rst_no_complete", 66'(n_cmp), 66'(cp));
    chk("post_rst_sb_empty", 66'(sb.size()), 66'd0);

    // Normal command after reset.
    expect_head(CMD_ADD, 32'h41000000);
    push_req(8'h41); push_req(8'h00); push_req(8'h00); push_req(8'h00);
    push_cmp(1'b0);
    issue(CMD_ADD, 5, 32'h41000000);
    wait_cmp(cp + 1);
    chk("after_rst_err", {65'd0, bus.err}, 66'd0);
    repeat (5) @(negedge clk);
    chk("sb_drained", 66'(sb.size()), 66'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
